act_scheduler: RTL

- Shares one registered activation unit (ReLU with saturation, 1-cycle latency) among NUM_NEURONS neuron accumulators of one layer.
- Captures each neuron's 2*dataWidth sum when it finishes, grants the activation unit round-robin, one sum per cycle, and tags each result with its neuron index.
- Signals layer completion once every neuron has been activated exactly once.
- Sits between the neuron MAC array and the next layer's input buffer.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/act_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron layer datapath.
package nn_pkg;

    localparam int DATA_W      = 16;
    localparam int ACC_W       = 32;
    localparam int MAX_NEURONS = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } act_state_t;

    typedef logic [$clog2(MAX_NEURONS)-1:0] neuron_idx_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: grants the first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    pos;

    // Bit k of rot is request (ptr + k) mod N.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: N];

    always_comb begin
        gnt_valid = 1'b0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && rot[k]) begin
                gnt_valid = 1'b1;
                pos       = {1'b0, ptr} + (IW+1)'(k);
            end
        end
        if (pos >= (IW+1)'(N)) begin
            pos = pos - (IW+1)'(N);
        end
        gnt_idx = pos[IW-1:0];
    end

endmodule

// File: rtl/act_scheduler.sv
// Shares one registered activation unit among a layer's neurons, round-robin,
// tagging each activated result with its neuron index.
module act_scheduler
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int dataWidth   = DATA_W,
    parameter int IDX_W       = idx_width(NUM_NEURONS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [NUM_NEURONS-1:0]             sum_valid,
    input  logic [NUM_NEURONS*2*dataWidth-1:0] sum_data,
    output logic                               act_valid,
    output logic [2*dataWidth-1:0]             act_in,
    input  logic [dataWidth-1:0]               act_out,
    output logic                               out_valid,
    output logic [dataWidth-1:0]               out_data,
    output logic [IDX_W-1:0]                   out_idx,
    output logic                               busy,
    output logic                               layer_done,
    output logic                               err_dup
);

    localparam int SW = 2 * dataWidth;

    act_state_t             state, state_next;
    logic [NUM_NEURONS-1:0] pending, served;
    logic [NUM_NEURONS-1:0] pending_next, served_next, capture;
    logic [SW-1:0]          sums [NUM_NEURONS];
    logic [IDX_W-1:0]       ptr, ptr_next, gnt_idx, idx1, idx2;
    logic                   gnt_valid, grant, dup_hit, v2;

    rr_arbiter #(
        .N  (NUM_NEURONS),
        .IW (IDX_W)
    ) u_arb (
        .req       (pending),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign grant    = (state == RUN) && gnt_valid;
    assign ptr_next = (gnt_idx == IDX_W'(NUM_NEURONS-1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (&served) state_next = DRAIN;
            // Last result is out when nothing remains in the two pipe stages behind it.
            DRAIN:   if (out_valid && !act_valid && !v2) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy       = (state != IDLE);
        layer_done = (state == DONE);
    end

    // A neuron already pending or served cannot be captured again, which also
    // covers a pulse arriving in the same cycle that neuron is granted.
    always_comb begin
        pending_next = pending;
        served_next  = served;
        capture      = '0;
        dup_hit      = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (sum_valid[i]) begin
                    if (pending[i] || served[i]) begin
                        dup_hit = 1'b1;
                    end else begin
                        capture[i]      = 1'b1;
                        pending_next[i] = 1'b1;
                    end
                end
            end
            if (gnt_valid) begin
                pending_next[gnt_idx] = 1'b0;
                served_next[gnt_idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= '0;
            served    <= '0;
            ptr       <= '0;
            err_dup   <= 1'b0;
            act_valid <= 1'b0;
            act_in    <= '0;
            idx1      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                pending   <= '0;
                served    <= '0;
                ptr       <= '0;
                err_dup   <= 1'b0;
                act_valid <= 1'b0;
            end else begin
                pending   <= pending_next;
                served    <= served_next;
                act_valid <= grant;
                if (dup_hit) err_dup <= 1'b1;
                if (grant) begin
                    act_in <= sums[gnt_idx];
                    idx1   <= gnt_idx;
                    ptr    <= ptr_next;
                end
            end
        end
    end

    // Sum storage is qualified by pending, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (capture[i]) sums[i] <= sum_data[i*SW +: SW];
        end
    end

    // act_out belongs to the act_in issued two edges earlier; v2/idx2 track it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            idx2      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            v2        <= act_valid;
            idx2      <= idx1;
            out_valid <= v2;
            if (v2) begin
                out_data <= act_out;
                out_idx  <= idx2;
            end
        end
    end

endmodule
